tt_uart_tx: RTL and testbench



---
 rtl/tt_uart_pkg.sv | 28 ++
 rtl/tt_uart_tx_if.sv | 10 +
 rtl/tt_uart_baud_cnt.sv | 29 ++
 rtl/tt_uart_tx.sv | 122 ++++++++++++
 tb/tb_tt_uart_tx.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/tt_uart_pkg.sv
// Shared types and legal parameter ranges for the TinyTapeout UART blocks.
// The TX and the future RX both import this package.
package tt_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int CLKS_PER_BIT_MAX = 65535;
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 8;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;

    function automatic bit uart_params_ok(input int cpb, input int db,
                                          input int par, input int sb);
        return (cpb >= CLKS_PER_BIT_MIN) && (cpb <= CLKS_PER_BIT_MAX) &&
               (db  >= DATA_BITS_MIN)    && (db  <= DATA_BITS_MAX)    &&
               (par == 0 || par == 1)    &&
               (sb  >= STOP_BITS_MIN)    && (sb  <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/tt_uart_tx_if.sv
// Byte handshake into the UART transmitter: the producer drives data/valid,
// and the transmitter answers with ready.
interface tt_uart_tx_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

// File: rtl/tt_uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and pulses bit_done on the last
// count. While clear is high, it holds at 0 so that a new bit starts aligned.
module tt_uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = !clear && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tt_uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bits.
// tx_o comes from a flop that loads the level of the next bit at each bit boundary.
module tt_uart_tx
    import tt_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    tt_uart_tx_if.slave  hs,
    output logic         tx_o,
    output logic         busy_o
);

    generate
        if (!uart_params_ok(CLKS_PER_BIT, DATA_BITS, PARITY_EN, STOP_BITS)) begin : g_bad_params
            $error("tt_uart_tx: parameter out of legal range");
        end
    endgenerate

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_tx_state_e       state;
    logic [DATA_BITS-1:0] shift;
    logic [BW-1:0]        bit_cnt;
    logic                 parity;
    logic                 bit_done;
    logic                 accept;

    // Baud counter sits at 0 through IDLE, so the start bit is a full period.
    tt_uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .bit_done (bit_done)
    );

    assign hs.ready_o = (state == IDLE) && ena && rst_n;
    assign accept     = hs.valid_i && hs.ready_o;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            parity  <= 1'b0;
            tx_o    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tx_o    <= 1'b1;
                    if (accept) begin
                        shift  <= hs.data_i[DATA_BITS-1:0];
                        parity <= ^hs.data_i[DATA_BITS-1:0];
                        state  <= START;
                        tx_o   <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx_o    <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= shift >> 1;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx_o  <= parity;
                            end else begin
                                state <= STOP;
                                tx_o  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // shift[0] is the bit leaving now; shift[1] goes out next
                            tx_o    <= shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        tx_o    <= 1'b1;
                    end
                end
                STOP: begin
                    tx_o <= 1'b1;
                    if (bit_done) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    tx_o    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_uart_tx.sv
// Directed bench for tt_uart_tx with two builds: 8N1 and 8E2, both at 4 clocks per bit.
// Each expected frame is written out by hand, one bit per transmitted slot.
module tb_tt_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena0 = 1'b1, ena1 = 1'b1;
    logic valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic tx0, tx1, busy0, busy1;
    logic sel = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tt_uart_tx_if hs0();
    tt_uart_tx_if hs1();
    assign hs0.data_i  = data0;
    assign hs0.valid_i = valid0;
    assign hs1.data_i  = data1;
    assign hs1.valid_i = valid1;

    tt_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena0), .hs(hs0), .tx_o(tx0), .busy_o(busy0));

    tt_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena1), .hs(hs1), .tx_o(tx1), .busy_o(busy1));

    logic tx_m, busy_m, rdy_m;
    assign tx_m   = sel ? tx1   : tx0;
    assign busy_m = sel ? busy1 : busy0;
    assign rdy_m  = sel ? hs1.ready_o : hs0.ready_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (sel) begin valid1 = v; data1 = d; end
        else     begin valid0 = v; data0 = d; end
    endtask

    // exp holds the frame in send order, first bit at exp[nb-1].
    task automatic frame(input logic [7:0] d, input logic [11:0] exp, input int nb,
                         input bit hold, input logic [7:0] nxt,
                         input int ena_drop, input int abort_at);
        int w;
        int idx;
        w = 0;
        while (!rdy_m && w < 200) begin tick(); w++; end
        if (!rdy_m) begin
            chk("ready_timeout", 32'(rdy_m), 32'd1);
            return;
        end
        drive(1'b1, d);
        tick();
        if (hold) drive(1'b1, nxt);
        else      drive(1'b0, ~d);
        for (int cyc = 1; cyc <= nb * CPB; cyc++) begin
            idx = (cyc - 1) / CPB;
            chk("tx_bit",    32'(tx_m),   32'(exp[nb-1-idx]));
            chk("rdy_busy",  32'(rdy_m),  32'd0);
            chk("busy_frm",  32'(busy_m), 32'd1);
            if (cyc == ena_drop) ena0 = 1'b0;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_tx",   32'(tx_m),   32'd1);
                chk("abort_busy", 32'(busy_m), 32'd0);
                chk("abort_rdy",  32'(rdy_m),  32'd0);
                tick();
                rst_n = 1'b1;
                return;
            end
            tick();
        end
        chk("end_tx",   32'(tx_m),   32'd1);
        chk("end_busy", 32'(busy_m), 32'd0);
        chk("end_rdy",  32'(rdy_m),  (ena_drop > 0) ? 32'd0 : 32'd1);
        if (ena_drop > 0) begin
            tick();
            chk("ena_off_rdy", 32'(rdy_m), 32'd0);
            chk("ena_off_tx",  32'(tx_m),  32'd1);
            ena0 = 1'b1;
            #1;
            chk("ena_on_rdy", 32'(rdy_m), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #12;
        chk("rst_tx0",   32'(tx0),         32'd1);
        chk("rst_busy0", 32'(busy0),       32'd0);
        chk("rst_rdy0",  32'(hs0.ready_o), 32'd0);
        chk("rst_tx1",   32'(tx1),         32'd1);
        chk("rst_rdy1",  32'(hs1.ready_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            chk("idle_tx",   32'(tx0),         32'd1);
            chk("idle_rdy",  32'(hs0.ready_o), 32'd1);
            chk("idle_busy", 32'(busy0),       32'd0);
            tick();
        end

        // 0xA5, 8N1
        sel = 1'b0;
        frame(8'hA5, 12'b0101001011, 10, 1'b0, 8'h00, 0, 0);

        // 0x07, 8E2: parity 1, two stop bits
        sel = 1'b1;
        frame(8'h07, 12'b011100000111, 12, 1'b0, 8'h00, 0, 0);

        // valid held: 0x00 then 0xFF with a single mark cycle between
        sel = 1'b0;
        frame(8'h00, 12'b0000000001, 10, 1'b1, 8'hFF, 0, 0);
        frame(8'hFF, 12'b0111111111, 10, 1'b0, 8'h00, 0, 0);

        // ena dropped at cycle 10 of 0x5A
        frame(8'h5A, 12'b0010110101, 10, 1'b0, 8'h00, 10, 0);

        // reset pulsed at cycle 15 of 0xA5, then 0x3C
        frame(8'hA5, 12'b0101001011, 10, 1'b0, 8'h00, 0, 15);
        chk("post_rst_busy", 32'(busy0), 32'd0);
        chk("post_rst_tx",   32'(tx0),   32'd1);
        frame(8'h3C, 12'b0001111001, 10, 1'b0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
